bit_stack_arb: RTL and testbench
================================

BIT_STACK_ARB -- requirements
Module: bit_stack_arb

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of bit positions in the attached bidirectional shift register.
REQ-002 The block SHALL have parameter CW, default 3, the width of the occupancy count, holding 0..DEPTH.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a_req, input, 1, requester A operation request, held high until a_ack.
REQ-006 The block SHALL have port a_op, input, 1, requester A operation: 0 = push, 1 = pop.
REQ-007 The block SHALL have port a_din, input, 1, requester A push data bit.
REQ-008 The block SHALL have ports b_req, b_op and b_din, inputs, 1 each, with the same meanings for requester B.
REQ-009 The block SHALL have ports a_ack and b_ack, outputs, 1 each, a one-cycle completion pulse per requester.
REQ-010 The block SHALL have ports a_err and b_err, outputs, 1 each, valid with ack; 1 = operation rejected.
REQ-011 The block SHALL have port dout, output, 1, the popped bit, valid with ack of a pop.
REQ-012 The block SHALL have port sr_in, output, 1, the data bit driven to the shift register in input.
REQ-013 The block SHALL have port sr_bsr, output, 1, the shift register push strobe.
REQ-014 The block SHALL have port sr_ret, output, 1, the shift register pop strobe.
REQ-015 The block SHALL have port sr_lifo, input, 1, the shift register lifoOut.
REQ-016 The block SHALL have ports count, output, CW, the occupancy; full, output, 1 (count==DEPTH); and empty, output, 1 (count==0).

Function
REQ-017 The FSM SHALL have states IDLE, STROBE, RELEASE and ACK; all outputs SHALL be registered.
REQ-018 In IDLE with any req high, the FSM SHALL grant one requester, latch its op/din, and move to STROBE, or to ACK for a rejected operation.
REQ-019 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; the first contention after reset SHALL grant A.
REQ-020 A push with full=1, or a pop with empty=1, SHALL be rejected: no strobe, count unchanged, ack with err=1, one cycle after the grant.
REQ-021 In STROBE, exactly one of sr_bsr (push) or sr_ret (pop) SHALL be high for exactly one cycle, with sr_in = latched din throughout STROBE.
REQ-022 count SHALL increment on leaving STROBE for a push and decrement for a pop; it SHALL never wrap.
REQ-023 In RELEASE, sr_bsr and sr_ret SHALL both be low for one cycle, giving the level-sensitive register a return-to-zero; sr_lifo SHALL be sampled at the end of RELEASE.
REQ-024 In ACK, only the granted requester's ack SHALL be high for one cycle; dout = sampled sr_lifo for a pop, 0 otherwise; the FSM then returns to IDLE.
REQ-025 An accepted operation SHALL take 4 cycles: grant edge, STROBE, RELEASE, ACK; ack SHALL occur 3 cycles after the grant edge.
REQ-026 req SHALL be sampled only in IDLE; a req still high in the IDLE following ACK SHALL be treated as a new request.
REQ-027 sr_bsr and sr_ret SHALL never be high in the same cycle, and neither SHALL be high outside STROBE.
REQ-028 a_op, a_din, b_op and b_din SHALL be ignored except on the grant edge.

Reset
REQ-029 While rst is high, the FSM SHALL be in IDLE with count=0, empty=1, full=0, and all ack, err, dout, sr_in, sr_bsr and sr_ret outputs at 0; the round-robin pointer SHALL favour A.
REQ-030 rst asserted mid-operation SHALL abort it without an ack; the shift register contents SHALL thereafter be treated as empty.

Verification
REQ-031 The bench SHALL check: A pushes 1,0,1,1 -> four acks with err=0, count 4, full=1, one sr_bsr pulse each, 3-cycle latency.
REQ-032 The bench SHALL check: then A pops four times -> dout 1,1,0,1, count 0, empty=1, one sr_ret pulse each followed by a low cycle.
REQ-033 The bench SHALL check: B pops when empty -> b_ack with b_err=1 one cycle after the grant, no sr_ret, count stays 0.
REQ-034 The bench SHALL check: push at full -> err=1, count stays 4, no sr_bsr.
REQ-035 The bench SHALL check: a_req and b_req held high continuously -> grants alternate A,B,A,B starting with A after reset.
REQ-036 The bench SHALL check: rst during STROBE of a push -> next cycle IDLE, count 0, sr_bsr 0, no ack issued.

Source files
------------

// File: rtl/bit_stack_arb.sv
// -----------------------------------------------------------------------------
// bit_stack_arb
//
// Two-requester arbiter in front of an external, level-sensitive bidirectional
// shift register that is used as a bit-wide LIFO stack. Each accepted
// operation follows the same sequence. The grant edge latches the operation.
// In STROBE one strobe is asserted for exactly one cycle. In RELEASE both
// strobes return to zero for one cycle. In ACK the granted requester receives
// a one-cycle acknowledge. Operations that would overflow or underflow the
// stack are rejected without touching the shift register. They are
// acknowledged one cycle after the grant, with err set.
//
// Ports
//   clk              single clock, rising edge
//   rst              synchronous active-high reset
//   a_req/b_req      operation request, held high until the matching ack
//   a_op/b_op        0 = push, 1 = pop (used only on the grant edge)
//   a_din/b_din      push data bit (used only on the grant edge)
//   a_ack/b_ack      one-cycle completion pulse
//   a_err/b_err      valid with ack, 1 = operation rejected
//   dout             popped bit, valid with ack of a pop, else 0
//   sr_in            data bit presented to the shift register
//   sr_bsr           shift register push strobe
//   sr_ret           shift register pop strobe
//   sr_lifo          shift register lifo output
//   count            stack occupancy, 0..DEPTH
//   full/empty       count == DEPTH / count == 0
//
// Every output is driven directly from a flop.
// -----------------------------------------------------------------------------
module bit_stack_arb #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_op,
  input  logic          a_din,
  input  logic          b_req,
  input  logic          b_op,
  input  logic          b_din,
  output logic          a_ack,
  output logic          b_ack,
  output logic          a_err,
  output logic          b_err,
  output logic          dout,
  output logic          sr_in,
  output logic          sr_bsr,
  output logic          sr_ret,
  input  logic          sr_lifo,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    RELEASE = 2'd2,
    ACK     = 2'd3
  } state_e;

  localparam logic [CW-1:0] CountMax = CW'(DEPTH);
  localparam logic [CW-1:0] CountOne = CW'(1);

  // Control state
  state_e        state_q,  state_d;
  logic          gnt_b_q,  gnt_b_d;   // current grantee: 1 = B, 0 = A
  logic          last_b_q, last_b_d;  // most recent grant went to B
  logic          op_q,     op_d;      // latched operation
  logic          din_q,    din_d;     // latched push data

  // Registered outputs
  logic [CW-1:0] count_q,  count_d;
  logic          full_q,   full_d;
  logic          empty_q,  empty_d;
  logic          a_ack_q,  a_ack_d;
  logic          b_ack_q,  b_ack_d;
  logic          a_err_q,  a_err_d;
  logic          b_err_q,  b_err_d;
  logic          dout_q,   dout_d;
  logic          sr_in_q,  sr_in_d;
  logic          sr_bsr_q, sr_bsr_d;
  logic          sr_ret_q, sr_ret_d;

  // Arbitration helpers, evaluated in IDLE
  logic          pick_b;
  logic          sel_op;
  logic          sel_din;
  logic          reject;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a
    // latch.
    state_d  = state_q;
    gnt_b_d  = gnt_b_q;
    last_b_d = last_b_q;
    op_d     = op_q;
    din_d    = din_q;
    count_d  = count_q;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;
    a_err_d  = 1'b0;
    b_err_d  = 1'b0;
    dout_d   = 1'b0;
    sr_in_d  = 1'b0;
    sr_bsr_d = 1'b0;
    sr_ret_d = 1'b0;

    // Round-robin selection. On contention B wins only when A was served
    // last. Otherwise whichever side is requesting is picked.
    pick_b  = b_req && (!a_req || !last_b_q);
    sel_op  = pick_b ? b_op  : a_op;
    sel_din = pick_b ? b_din : a_din;
    reject  = sel_op ? empty_q : full_q;

    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          gnt_b_d  = pick_b;
          last_b_d = pick_b;
          op_d     = sel_op;
          din_d    = sel_din;
          if (reject) begin
            // Skip the shift register entirely and acknowledge next cycle.
            state_d = ACK;
            a_ack_d = !pick_b;
            b_ack_d = pick_b;
            a_err_d = !pick_b;
            b_err_d = pick_b;
          end else begin
            state_d  = STROBE;
            sr_in_d  = sel_din;
            sr_bsr_d = !sel_op;
            sr_ret_d = sel_op;
          end
        end
      end

      STROBE: begin
        // The strobe drops on this edge. The occupancy moves with it.
        // The full/empty guards stop count from ever wrapping.
        state_d = RELEASE;
        if (op_q) begin
          if (!empty_q) count_d = count_q - CountOne;
        end else begin
          if (!full_q) count_d = count_q + CountOne;
        end
      end

      RELEASE: begin
        // Both strobes stay low for this cycle. The shift register output
        // has settled by the end of it, so it is captured for the ack.
        state_d = ACK;
        a_ack_d = !gnt_b_q;
        b_ack_d = gnt_b_q;
        dout_d  = op_q & sr_lifo;
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    full_d  = (count_d == CountMax);
    empty_d = (count_d == '0);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: flops are updated with non-blocking assignments, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_b_q  <= 1'b0;
      last_b_q <= 1'b1;  // pretend B went last so A wins first contention
      op_q     <= 1'b0;
      din_q    <= 1'b0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      a_err_q  <= 1'b0;
      b_err_q  <= 1'b0;
      dout_q   <= 1'b0;
      sr_in_q  <= 1'b0;
      sr_bsr_q <= 1'b0;
      sr_ret_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_b_q  <= gnt_b_d;
      last_b_q <= last_b_d;
      op_q     <= op_d;
      din_q    <= din_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      a_err_q  <= a_err_d;
      b_err_q  <= b_err_d;
      dout_q   <= dout_d;
      sr_in_q  <= sr_in_d;
      sr_bsr_q <= sr_bsr_d;
      sr_ret_q <= sr_ret_d;
    end
  end

  assign a_ack  = a_ack_q;
  assign b_ack  = b_ack_q;
  assign a_err  = a_err_q;
  assign b_err  = b_err_q;
  assign dout   = dout_q;
  assign sr_in  = sr_in_q;
  assign sr_bsr = sr_bsr_q;
  assign sr_ret = sr_ret_q;
  assign count  = count_q;
  assign full   = full_q;
  assign empty  = empty_q;

endmodule

// File: tb/tb_bit_stack_arb.sv
// -----------------------------------------------------------------------------
// tb_bit_stack_arb
//
// Directed bench for bit_stack_arb. A small behavioural model of the external
// bit-wide shift register stack is attached to the sr_* ports. Monitors count
// strobe pulses, overlaps and acks. Outputs are sampled 1 time unit after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_bit_stack_arb;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_op, a_din;
  logic          b_req, b_op, b_din;
  logic          a_ack, b_ack, a_err, b_err;
  logic          dout;
  logic          sr_in, sr_bsr, sr_ret;
  logic          sr_lifo;
  logic [CW-1:0] count;
  logic          full, empty;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_stack_arb #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_req  (a_req),
    .a_op   (a_op),
    .a_din  (a_din),
    .b_req  (b_req),
    .b_op   (b_op),
    .b_din  (b_din),
    .a_ack  (a_ack),
    .b_ack  (b_ack),
    .a_err  (a_err),
    .b_err  (b_err),
    .dout   (dout),
    .sr_in  (sr_in),
    .sr_bsr (sr_bsr),
    .sr_ret (sr_ret),
    .sr_lifo(sr_lifo),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Shift register stack model. A push stores sr_in on top. A pop moves the
  // top bit to the lifo output, where it stays until the next pop.
  logic stk [DEPTH];
  int   sp = 0;
  logic lifo_q = 1'b0;
  assign sr_lifo = lifo_q;

  always @(posedge clk) begin
    if (rst) begin
      sp     <= 0;
      lifo_q <= 1'b0;
    end else if (sr_bsr && sp < DEPTH) begin
      stk[sp] <= sr_in;
      sp      <= sp + 1;
    end else if (sr_ret && sp > 0) begin
      lifo_q <= stk[sp-1];
      sp     <= sp - 1;
    end
  end

  // Monitors
  int   bsr_cnt = 0, ret_cnt = 0, overlap_cnt = 0, rtz_bad = 0;
  int   a_ack_cnt = 0, b_ack_cnt = 0;
  logic prev_bsr = 1'b0, prev_ret = 1'b0;
  logic grant_q [$];

  always @(posedge clk) begin
    if (sr_bsr) bsr_cnt++;
    if (sr_ret) ret_cnt++;
    if (sr_bsr && sr_ret) overlap_cnt++;
    if ((sr_bsr && prev_bsr) || (sr_ret && prev_ret)) rtz_bad++;
    prev_bsr = sr_bsr;
    prev_ret = sr_ret;
    if (a_ack) begin a_ack_cnt++; grant_q.push_back(1'b0); end
    if (b_ack) begin b_ack_cnt++; grant_q.push_back(1'b1); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one operation from A (use_b=0) or B (use_b=1). Wait for the ack
  // and check the latency from the grant edge, err, dout and strobe counts.
  // op/din are inverted right after the grant edge; the DUT must ignore that.
  task automatic do_op(input string tag, input logic use_b, input logic op,
                       input logic din, input int exp_lat, input logic exp_err,
                       input logic exp_dout);
    int   n   = 0;
    logic got = 1'b0;
    int   b0  = bsr_cnt;
    int   r0  = ret_cnt;
    logic other;
    logic err;
    @(negedge clk);
    if (use_b) begin b_req = 1'b1; b_op = op; b_din = din; end
    else       begin a_req = 1'b1; a_op = op; a_din = din; end
    while (!got && n < 12) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        if (use_b) begin b_op = ~op; b_din = ~din; end
        else       begin a_op = ~op; a_din = ~din; end
      end
      got = use_b ? b_ack : a_ack;
    end
    other = use_b ? a_ack : b_ack;
    err   = use_b ? b_err : a_err;
    check({tag, "_lat"},   got ? n : -1, exp_lat);
    check({tag, "_err"},   err, exp_err);
    check({tag, "_other"}, other, 1'b0);
    check({tag, "_dout"},  dout, exp_dout);
    check({tag, "_bsr"},   bsr_cnt - b0, (!op && !exp_err) ? 1 : 0);
    check({tag, "_ret"},   ret_cnt - r0, ( op && !exp_err) ? 1 : 0);
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int acks0;
    rst = 1'b1;
    a_req = 1'b0; a_op = 1'b0; a_din = 1'b0;
    b_req = 1'b0; b_op = 1'b0; b_din = 1'b0;

    // Reset state, observed while rst is still high
    repeat (3) @(posedge clk);
    #1;
    check("rst_count",  count, 0);
    check("rst_empty",  empty, 1);
    check("rst_full",   full, 0);
    check("rst_a_ack",  a_ack, 0);
    check("rst_b_ack",  b_ack, 0);
    check("rst_err",    {a_err, b_err}, 0);
    check("rst_dout",   dout, 0);
    check("rst_sr_in",  sr_in, 0);
    check("rst_strobe", {sr_bsr, sr_ret}, 0);
    @(negedge clk);
    rst = 1'b0;

    // A pushes 1,0,1,1
    do_op("push0", 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    do_op("push1", 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    do_op("push2", 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    do_op("push3", 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    #1;
    check("fill_count", count, 4);
    check("fill_full",  full, 1);
    check("fill_empty", empty, 0);

    // A pops four times: LIFO order 1,1,0,1
    do_op("pop0", 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b1);
    do_op("pop1", 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b1);
    do_op("pop2", 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0);
    do_op("pop3", 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b1);
    #1;
    check("drain_count", count, 0);
    check("drain_empty", empty, 1);
    check("drain_full",  full, 0);

    // B pops while empty: rejected, one cycle after the grant
    do_op("b_pop_empty", 1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    #1;
    check("b_pop_empty_count", count, 0);

    // Refill, then push at full
    do_op("refill0", 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    do_op("refill1", 1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    do_op("refill2", 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    do_op("refill3", 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    do_op("push_full", 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0);
    #1;
    check("push_full_count", count, 4);
    check("push_full_full",  full, 1);

    // Round robin with both requests held high, starting fresh from reset
    do_reset();
    grant_q.delete();
    a_req = 1'b1; a_op = 1'b0; a_din = 1'b1;
    b_req = 1'b1; b_op = 1'b0; b_din = 1'b0;
    n = 0;
    while (grant_q.size() < 4 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("rr_num_grants", grant_q.size(), 4);
    if (grant_q.size() >= 4) begin
      check("rr_g0", grant_q[0], 1'b0);
      check("rr_g1", grant_q[1], 1'b1);
      check("rr_g2", grant_q[2], 1'b0);
      check("rr_g3", grant_q[3], 1'b1);
    end
    repeat (6) @(posedge clk);
    #1;
    check("rr_count", count, 4);
    check("rr_grants_total", grant_q.size(), 4);

    // Reset during STROBE of a push aborts without an ack
    do_reset();
    acks0 = a_ack_cnt + b_ack_cnt;
    @(negedge clk);
    a_req = 1'b1; a_op = 1'b0; a_din = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_strobe", sr_bsr, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_count", count, 0);
    check("abort_empty", empty, 1);
    check("abort_bsr",   sr_bsr, 0);
    check("abort_ack",   a_ack, 0);
    rst   = 1'b0;
    a_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_ack", a_ack_cnt + b_ack_cnt, acks0);
    do_op("post_abort", 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    #1;
    check("post_abort_count", count, 1);

    // Global strobe hygiene across the whole run
    check("strobe_overlap", overlap_cnt, 0);
    check("strobe_rtz",     rtz_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
